// File: rtl/aes_spi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : aes_spi_bridge
// Brief    : Oversampled SPI front end that loads a plaintext+key frame into
//            aes_core, then shifts the captured cyphertext back to the host.
// Revision : 1.0 - initial release
// ============================================================================
module aes_spi_bridge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sck,
    input  logic         sdi,
    input  logic         load,
    output logic         sdo,
    output logic         done,
    output logic         ce,
    output logic [127:0] key,
    output logic [127:0] plaintext,
    input  logic         core_done,
    input  logic [127:0] cyphertext,
    output logic         frame_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WAIT  = 2'd2,
        READY = 2'd3
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic [SYNC_STAGES-1:0] load_sync;
    logic [SYNC_STAGES-1:0] cdone_sync;
    logic                   sck_q;
    logic                   load_q;
    logic                   cdone_q;
    logic [255:0]           shreg;
    logic [127:0]           oreg;
    logic [8:0]             bitcnt;
    logic [8:0]             bitcnt_nxt;
    logic [7:0]             ocnt;

    logic sck_s;
    logic sdi_s;
    logic load_s;
    logic cdone_s;
    logic sck_r;
    logic sck_f;
    logic load_r;
    logic load_f;
    logic done_r;

    assign sck_s   = sck_sync[SYNC_STAGES-1];
    assign sdi_s   = sdi_sync[SYNC_STAGES-1];
    assign load_s  = load_sync[SYNC_STAGES-1];
    assign cdone_s = cdone_sync[SYNC_STAGES-1];

    assign sck_r  = sck_s & ~sck_q;
    assign sck_f  = ~sck_s & sck_q;
    assign load_r = load_s & ~load_q;
    assign load_f = ~load_s & load_q;
    assign done_r = cdone_s & ~cdone_q;

    assign plaintext = shreg[255:128];
    assign key       = shreg[127:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync   <= '0;
            sdi_sync   <= '0;
            load_sync  <= '0;
            cdone_sync <= '0;
            sck_q      <= 1'b0;
            load_q     <= 1'b0;
            cdone_q    <= 1'b0;
        end else begin
            sck_sync   <= {sck_sync[SYNC_STAGES-2:0], sck};
            sdi_sync   <= {sdi_sync[SYNC_STAGES-2:0], sdi};
            load_sync  <= {load_sync[SYNC_STAGES-2:0], load};
            cdone_sync <= {cdone_sync[SYNC_STAGES-2:0], core_done};
            sck_q      <= sck_s;
            load_q     <= load_s;
            cdone_q    <= cdone_s;
        end
    end

    // Count including a shift in this very cycle, so a last sck edge that
    // lands together with the load fall still completes the frame.
    always_comb begin
        bitcnt_nxt = bitcnt;
        if (sck_r && (bitcnt != 9'd256)) begin
            bitcnt_nxt = bitcnt + 9'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            oreg      <= '0;
            bitcnt    <= '0;
            ocnt      <= '0;
            ce        <= 1'b0;
            done      <= 1'b0;
            sdo       <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            ce        <= (state == LOAD);
            done      <= (state == READY);
            sdo       <= oreg[127];

            if (load_r && (state != LOAD)) begin
                state     <= LOAD;
                bitcnt    <= '0;
                frame_err <= (state == WAIT) || (state == READY);
            end else begin
                case (state)
                    IDLE: begin
                    end
                    LOAD: begin
                        if (sck_r) begin
                            shreg  <= {shreg[254:0], sdi_s};
                            bitcnt <= bitcnt_nxt;
                        end
                        if (load_f) begin
                            if (bitcnt_nxt == 9'd256) begin
                                state <= WAIT;
                            end else begin
                                state     <= IDLE;
                                frame_err <= 1'b1;
                            end
                        end
                    end
                    // Only a fresh rise counts; a level left high by an
                    // earlier run never produces done_r here.
                    WAIT: begin
                        if (done_r) begin
                            oreg  <= cyphertext;
                            ocnt  <= '0;
                            state <= READY;
                        end
                    end
                    READY: begin
                        if (sck_f) begin
                            oreg <= {oreg[126:0], 1'b0};
                            ocnt <= ocnt + 8'd1;
                            if (ocnt == 8'd127) begin
                                state <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_spi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_spi_bridge
// Brief    : Self-checking bench: SPI host model, stub AES core, vector table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_spi_bridge;

    localparam int SYNC   = 2;
    localparam int PH_MIN = SYNC + 2;

    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         reset;
    logic         sck;
    logic         sdi;
    logic         load;
    logic         sdo;
    logic         done;
    logic         ce;
    logic [127:0] key;
    logic [127:0] plaintext;
    logic         core_done;
    logic [127:0] cyphertext;
    logic         frame_err;

    int checks   = 0;
    int errors   = 0;
    int ferr_cnt = 0;
    int done_cyc = 0;

    typedef struct {
        logic [127:0] pt;
        logic [127:0] k;
        logic [127:0] ct;
        int           ph;
    } vec_t;

    vec_t         vecs [4];
    int           f0;
    int           d0;
    logic [127:0] got;
    logic [127:0] pa, ka, pb, kb;
    logic [127:0] exp40, got40;

    always #5 clk = ~clk;

    aes_spi_bridge #(.SYNC_STAGES(SYNC)) dut (
        .clk        (clk),
        .reset      (reset),
        .sck        (sck),
        .sdi        (sdi),
        .load       (load),
        .sdo        (sdo),
        .done       (done),
        .ce         (ce),
        .key        (key),
        .plaintext  (plaintext),
        .core_done  (core_done),
        .cyphertext (cyphertext),
        .frame_err  (frame_err)
    );

    always @(posedge clk) begin
        if (frame_err === 1'b1) ferr_cnt++;
        if (done === 1'b1) done_cyc++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, got no summary, required finish");
        $fatal(1, "timeout");
    end

    // Stand-in for aes_core: the known FIPS-197 answer, otherwise a cheap mix.
    function automatic logic [127:0] core_model(input logic [127:0] pt, input logic [127:0] k);
        if (pt == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
        return pt ^ {k[63:0], k[127:64]} ^ 128'hA5A5A5A5_0F0F0F0F_3C3C3C3C_96969696;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [255:0] frame, input int nbits,
                              input int ph, input bit keep_done);
        if (!keep_done) core_done = 1'b0;
        load = 1'b1;
        tick(SYNC + 1);
        chk1("ce_before_latency", ce, 1'b0);
        tick(1);
        chk1("ce_rise_latency", ce, 1'b1);
        if (ph > PH_MIN) tick(ph - PH_MIN);
        for (int i = 0; i < nbits; i++) begin
            sdi = frame[255 - i];
            tick(ph);
            sck = 1'b1;
            tick(ph);
            sck = 1'b0;
        end
        tick(ph);
        load = 1'b0;
        sdi  = 1'($urandom_range(0, 1));
        tick(SYNC + 1);
        chk1("ce_hold_after_load_fall", ce, 1'b1);
        tick(1);
        chk1("ce_fall_latency", ce, 1'b0);
    endtask

    task automatic core_respond();
        cyphertext = core_model(plaintext, key);
        core_done  = 1'b1;
        tick(SYNC + 1);
        chk1("done_before_latency", done, 1'b0);
        tick(1);
        chk1("done_rise_latency", done, 1'b1);
    endtask

    task automatic read_out(input int nbits, input int ph, output logic [127:0] res);
        res = '0;
        for (int i = 0; i < nbits; i++) begin
            res = {res[126:0], sdo};
            sdi = 1'($urandom_range(0, 1));
            sck = 1'b1;
            tick(ph);
            sck = 1'b0;
            tick(ph);
        end
    endtask

    task automatic run_vector(input logic [127:0] pt, input logic [127:0] k,
                              input logic [127:0] exp_ct, input int ph);
        logic [127:0] r;
        int           fe;
        fe = ferr_cnt;
        send_frame({pt, k}, 256, ph, 1'b0);
        chk("plaintext", plaintext, pt);
        chk("key", key, k);
        tick(5);
        chk1("done_idle_in_wait", done, 1'b0);
        core_respond();
        chk1("sdo_first_bit", sdo, exp_ct[127]);
        read_out(128, ph, r);
        chk("readout", r, exp_ct);
        chk1("done_after_readout", done, 1'b0);
        chk1("ce_after_readout", ce, 1'b0);
        chk32("no_frame_err", ferr_cnt - fe, 0);
    endtask

    initial begin
        vecs[0] = '{pt: FIPS_PT, k: FIPS_KEY, ct: FIPS_CT, ph: 6};
        for (int i = 1; i < 4; i++) begin
            vecs[i].pt = rand128();
            vecs[i].k  = rand128();
            vecs[i].ct = core_model(vecs[i].pt, vecs[i].k);
            vecs[i].ph = int'($urandom_range(PH_MIN, PH_MIN + 2));
        end

        reset      = 1'b1;
        sck        = 1'b0;
        sdi        = 1'b0;
        load       = 1'b0;
        core_done  = 1'b0;
        cyphertext = '0;
        tick(3);
        chk1("reset_ce", ce, 1'b0);
        chk1("reset_done", done, 1'b0);
        chk1("reset_sdo", sdo, 1'b0);
        chk1("reset_frame_err", frame_err, 1'b0);
        chk("reset_key", key, '0);
        chk("reset_plaintext", plaintext, '0);
        reset = 1'b0;
        tick(3);

        for (int i = 0; i < 4; i++) begin
            run_vector(vecs[i].pt, vecs[i].k, vecs[i].ct, vecs[i].ph);
            tick(4);
        end

        // Short frame: 255 bits then load falls.
        f0 = ferr_cnt;
        d0 = done_cyc;
        send_frame({rand128(), rand128()}, 255, 5, 1'b0);
        chk32("short_frame_err", ferr_cnt - f0, 1);
        cyphertext = rand128();
        core_done  = 1'b1;
        tick(12);
        chk32("short_done_never", done_cyc - d0, 0);
        chk1("short_ce", ce, 1'b0);

        // Restart while waiting for the core.
        pa = rand128(); ka = rand128();
        pb = rand128(); kb = rand128();
        send_frame({pa, ka}, 256, 5, 1'b0);
        tick(10);
        f0 = ferr_cnt;
        send_frame({pb, kb}, 256, 5, 1'b0);
        chk32("restart_frame_err", ferr_cnt - f0, 1);
        chk("restart_plaintext", plaintext, pb);
        chk("restart_key", key, kb);
        core_respond();
        read_out(128, 5, got);
        chk("restart_readout", got, core_model(pb, kb));

        // Reset after 40 bits of read-out.
        tick(4);
        pa = rand128(); ka = rand128();
        send_frame({pa, ka}, 256, 5, 1'b0);
        core_respond();
        read_out(40, 5, got);
        exp40 = core_model(pa, ka) >> 88;
        got40 = {88'd0, got[39:0]};
        chk("partial_readout", got40, exp40);
        reset = 1'b1;
        tick(1);
        chk1("midreset_ce", ce, 1'b0);
        chk1("midreset_done", done, 1'b0);
        chk1("midreset_sdo", sdo, 1'b0);
        chk1("midreset_frame_err", frame_err, 1'b0);
        chk("midreset_key", key, '0);
        chk("midreset_plaintext", plaintext, '0);
        reset = 1'b0;
        tick(3);
        pb = rand128(); kb = rand128();
        run_vector(pb, kb, core_model(pb, kb), 5);

        // Minimum sck phases with core_done already high entering WAIT.
        tick(4);
        pa = rand128(); ka = rand128();
        cyphertext = rand128();
        core_done  = 1'b1;
        tick(8);
        send_frame({pa, ka}, 256, PH_MIN, 1'b1);
        chk("slow_plaintext", plaintext, pa);
        chk("slow_key", key, ka);
        tick(20);
        chk1("stale_done_ignored", done, 1'b0);
        core_done = 1'b0;
        tick(6);
        core_respond();
        chk1("slow_sdo_first", sdo, core_model(pa, ka) >> 127 != 0);
        read_out(128, PH_MIN, got);
        chk("slow_readout", got, core_model(pa, ka));
        chk1("slow_done_after", done, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
